// File: rtl/rd_line_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_line_collector_pkg
// Description : Shared constants and types for the read-return line collector.
// Revision    : 1.0 - initial release
// ============================================================================
package rd_line_collector_pkg;

    localparam int c_LINE_WORDS = 4;
    localparam int c_WORD_WIDTH = 32;
    localparam int c_LINE_WIDTH = c_LINE_WORDS * c_WORD_WIDTH;
    localparam int c_DEST_WIDTH = 4;

    // RDdest value meaning "no word on the return path this cycle"
    localparam logic [c_DEST_WIDTH-1:0] c_DEST_NULL = 4'd0;

    // Line-assembly state
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } collectState_t;

endpackage : rd_line_collector_pkg
`default_nettype wire

// File: rtl/rd_line_collector_fifo.sv
`default_nettype none
// ============================================================================
// Module      : line_fifo
// Description : Synchronous FIFO of assembled lines. Head is presented
//               combinationally; when empty the last popped line is held.
// Revision    : 1.0 - initial release
// ============================================================================
module line_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH_CNT = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;
    logic [WIDTH-1:0]   r_hold;
    logic               w_doPush;
    logic               w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == c_DEPTH_CNT);
    assign w_doPop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_data   = o_empty ? r_hold : r_mem[r_rdPtr];

    // Storage array: written only on an accepted push, never reset
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers, occupancy and the held copy of the last popped line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
                r_hold  <= r_mem[r_rdPtr];
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : line_fifo
`default_nettype wire

// File: rtl/rd_line_collector.sv
`default_nettype none
// ============================================================================
// Module      : rd_line_collector
// Description : Collects four read-return words addressed to this ring
//               station into a 128-bit line, buffers lines in a FIFO and
//               tracks the number of reads still outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_line_collector
    import rd_line_collector_pkg::*;
#(
    parameter logic [3:0] CORE_ID         = 4'd1,
    parameter int         FIFO_DEPTH      = 4,
    parameter int         MAX_OUTSTANDING = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  RDreturn,
    input  logic [3:0]   RDdest,
    input  logic         readIssued,
    output logic [127:0] lineData,
    output logic         lineValid,
    input  logic         lineReady,
    output logic [2:0]   outstanding,
    output logic         busy,
    output logic         overflow,
    output logic         spurious
);

    localparam logic [2:0] c_MAX_OUT = 3'(MAX_OUTSTANDING);

    collectState_t r_state;
    logic [1:0]    r_wordCnt;
    logic [95:0]   r_lineLow;
    logic          r_busy;
    logic [2:0]    r_outstanding;
    logic          r_overflow;
    logic          r_spurious;

    logic          w_accept;
    logic          w_complete;
    logic          w_pop;
    logic          w_push;
    logic          w_fifoFull;
    logic          w_fifoEmpty;
    logic [127:0]  w_line;

    // A word is ours only when addressed to this station; the null code never matches
    assign w_accept   = (RDdest == CORE_ID) && (RDdest != c_DEST_NULL);
    assign w_complete = w_accept && (r_wordCnt == 2'd3);
    assign w_line     = {RDreturn, r_lineLow};
    assign w_pop      = lineValid && lineReady;
    // A completed line that finds the FIFO full with no pop is dropped
    assign w_push     = w_complete && (!w_fifoFull || w_pop);

    assign lineValid   = !w_fifoEmpty;
    assign busy        = r_busy;
    assign outstanding = r_outstanding;
    assign overflow    = r_overflow;
    assign spurious    = r_spurious;

    // Collection FSM: word counter, state and registered busy flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wordCnt <= 2'd0;
            r_busy    <= 1'b0;
        end else if (w_accept) begin
            r_wordCnt <= r_wordCnt + 2'd1;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_COLLECT;
                    r_busy  <= 1'b1;
                end
                ST_COLLECT: begin
                    if (r_wordCnt == 2'd3) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Capture words 0..2; word 3 goes straight from RDreturn into the FIFO
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lineLow <= '0;
        end else if (w_accept) begin
            case (r_wordCnt)
                2'd0:    r_lineLow[31:0]  <= RDreturn;
                2'd1:    r_lineLow[63:32] <= RDreturn;
                2'd2:    r_lineLow[95:64] <= RDreturn;
                default: r_lineLow        <= r_lineLow;
            endcase
        end
    end

    // Outstanding-read counter with sticky overflow/spurious error flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_outstanding <= 3'd0;
            r_overflow    <= 1'b0;
            r_spurious    <= 1'b0;
        end else begin
            if (w_complete && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_complete && (r_outstanding == 3'd0)) begin
                r_spurious <= 1'b1;
            end
            if (readIssued && !w_complete) begin
                if (r_outstanding == c_MAX_OUT) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_outstanding <= r_outstanding + 3'd1;
                end
            end else if (w_complete && !readIssued) begin
                if (r_outstanding != 3'd0) begin
                    r_outstanding <= r_outstanding - 3'd1;
                end
            end
        end
    end

    line_fifo #(
        .WIDTH (c_LINE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_lineFifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_line),
        .o_data  (lineData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

endmodule : rd_line_collector
`default_nettype wire
